// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_pkg
// Description : ALU data widths, opcode encodings and opcode legality helper.
// Revision    : 1.0
// ============================================================================
package alu_pkg;

    localparam int DATA_W = 32;
    localparam int OPC_W  = 7;

    localparam logic [OPC_W-1:0] OP_OR  = 7'h00;
    localparam logic [OPC_W-1:0] OP_AND = 7'h01;
    localparam logic [OPC_W-1:0] OP_XOR = 7'h02;
    localparam logic [OPC_W-1:0] OP_ADD = 7'h03;

    function automatic logic is_legal_op(input logic [OPC_W-1:0] opc);
        return (opc <= OP_ADD);
    endfunction

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo
// Description : Registered-count synchronous FIFO; full/empty derive from count.
// Revision    : 1.0
// ============================================================================
module sync_fifo #(
    parameter int WIDTH = 71,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    head;
    logic [AW-1:0]    tail;
    logic             wr_ok;
    logic             rd_ok;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign wr_ok   = wr_en && !full;
    assign rd_ok   = rd_en && !empty;
    assign rd_data = mem[head];

    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[tail] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (wr_ok) begin
                tail <= tail + AW'(1);
            end
            if (rd_ok) begin
                head <= head + AW'(1);
            end
            case ({wr_ok, rd_ok})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/alu_issue_queue.sv
`default_nettype none
// ============================================================================
// Module      : alu_issue_queue
// Description : Buffers ALU operations and issues one per cycle with result tags.
// Revision    : 1.0
// ============================================================================
module alu_issue_queue
    import alu_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int TAG_W = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [OPC_W-1:0]        in_opcode,
    input  logic [DATA_W-1:0]       in_a,
    input  logic [DATA_W-1:0]       in_b,
    input  logic                    issue_en,
    output logic [DATA_W-1:0]       alu_a,
    output logic [DATA_W-1:0]       alu_b,
    output logic [OPC_W-1:0]        alu_opcode,
    output logic                    alu_issue,
    output logic                    res_valid,
    output logic [TAG_W-1:0]        res_tag,
    output logic [OPC_W-1:0]        res_opcode,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    illegal_op
);

    localparam int FIFO_W = OPC_W + 2 * DATA_W;

    logic              fifo_full;
    logic              fifo_empty;
    logic              accept;
    logic              legal;
    logic              enq;
    logic              do_issue;
    logic [FIFO_W-1:0] head_entry;
    logic [TAG_W-1:0]  tag_cnt;
    logic [TAG_W-1:0]  issue_tag;

    assign in_ready = !rst && !fifo_full;
    assign accept   = in_valid && in_ready;
    assign legal    = is_legal_op(in_opcode);
    assign enq      = accept && legal;
    // The FIFO count is registered, so a fresh entry is never issued in its enqueue cycle.
    assign do_issue = issue_en && !fifo_empty;

    sync_fifo #(
        .WIDTH (FIFO_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (enq),
        .wr_data ({in_opcode, in_a, in_b}),
        .rd_en   (do_issue),
        .rd_data (head_entry),
        .count   (count),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            alu_a      <= '0;
            alu_b      <= '0;
            alu_opcode <= '0;
            alu_issue  <= 1'b0;
            res_valid  <= 1'b0;
            res_tag    <= '0;
            res_opcode <= '0;
            illegal_op <= 1'b0;
            tag_cnt    <= '0;
            issue_tag  <= '0;
        end else begin
            alu_issue  <= do_issue;
            illegal_op <= accept && !legal;
            // The ALU registers O one edge after issue; this stage tracks that edge.
            res_valid  <= alu_issue;
            if (do_issue) begin
                {alu_opcode, alu_a, alu_b} <= head_entry;
                issue_tag                  <= tag_cnt;
                tag_cnt                    <= tag_cnt + TAG_W'(1);
            end
            if (alu_issue) begin
                res_tag    <= issue_tag;
                res_opcode <= alu_opcode;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_issue_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_issue_queue
// Description : Scoreboard bench for alu_issue_queue against a queue-based model.
// Revision    : 1.0
// ============================================================================
module tb_alu_issue_queue;

    localparam int DEPTH = 4;
    localparam int TAG_W = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [6:0]  in_opcode;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic        issue_en;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [6:0]  alu_opcode;
    logic        alu_issue;
    logic        res_valid;
    logic [3:0]  res_tag;
    logic [6:0]  res_opcode;
    logic [2:0]  count;
    logic        illegal_op;

    alu_issue_queue #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_opcode  (in_opcode),
        .in_a       (in_a),
        .in_b       (in_b),
        .issue_en   (issue_en),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_opcode (alu_opcode),
        .alu_issue  (alu_issue),
        .res_valid  (res_valid),
        .res_tag    (res_tag),
        .res_opcode (res_opcode),
        .count      (count),
        .illegal_op (illegal_op)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [6:0]  opc;
        logic [31:0] a;
        logic [31:0] b;
    } op_t;

    typedef struct {
        logic [3:0] tag;
        logic [6:0] opc;
    } res_t;

    // Reference model: a plain queue of pending ops plus the expected ALU-side view.
    op_t         mq[$];
    res_t        exp_res[$];
    int          m_tag;
    logic        exp_ill;
    logic        exp_iss;
    logic        exp_rv;
    logic [31:0] exp_a;
    logic [31:0] exp_b;
    logic [6:0]  exp_opc;
    bit          m_full;
    bit          m_iss;
    bit          m_acc;
    op_t         m_e;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        if (rst) begin
            mq.delete();
            exp_res.delete();
            m_tag   = 0;
            exp_ill = 1'b0;
            exp_iss = 1'b0;
            exp_rv  = 1'b0;
            exp_a   = '0;
            exp_b   = '0;
            exp_opc = '0;
        end else begin
            m_full  = (mq.size() == DEPTH);
            m_iss   = (mq.size() > 0) && issue_en;
            m_acc   = in_valid && !m_full;
            exp_rv  = exp_iss;
            exp_iss = m_iss;
            exp_ill = m_acc && (in_opcode > 7'h03);
            if (m_iss) begin
                m_e     = mq.pop_front();
                exp_a   = m_e.a;
                exp_b   = m_e.b;
                exp_opc = m_e.opc;
                exp_res.push_back('{tag: 4'(m_tag), opc: m_e.opc});
                m_tag   = (m_tag + 1) % (1 << TAG_W);
            end
            if (m_acc && (in_opcode <= 7'h03)) begin
                mq.push_back('{opc: in_opcode, a: in_a, b: in_b});
            end
        end
    end

    res_t got;
    always @(negedge clk) begin
        chk("in_ready",   32'(in_ready),   32'(!rst && (mq.size() < DEPTH)));
        chk("count",      32'(count),      32'(mq.size()));
        chk("illegal_op", 32'(illegal_op), 32'(exp_ill));
        chk("alu_issue",  32'(alu_issue),  32'(exp_iss));
        chk("alu_a",      alu_a,           exp_a);
        chk("alu_b",      alu_b,           exp_b);
        chk("alu_opcode", 32'(alu_opcode), 32'(exp_opc));
        chk("res_valid",  32'(res_valid),  32'(exp_rv));
        if (res_valid) begin
            if (exp_res.size() == 0) begin
                chk("res_spurious", 32'(1), 32'(0));
            end else begin
                got = exp_res.pop_front();
                chk("res_tag",    32'(res_tag),    32'(got.tag));
                chk("res_opcode", 32'(res_opcode), 32'(got.opc));
            end
        end
    end

    task automatic drive(input logic v, input logic [6:0] opc, input logic [31:0] a,
                         input logic [31:0] b, input logic ie, input logic r);
        @(negedge clk);
        #1;
        in_valid  = v;
        in_opcode = opc;
        in_a      = a;
        in_b      = b;
        issue_en  = ie;
        rst       = r;
    endtask

    task automatic idle(input int n, input logic ie);
        for (int i = 0; i < n; i++) drive(1'b0, 7'h00, 32'h0, 32'h0, ie, 1'b0);
    endtask

    logic [6:0] ropc;

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_opcode = '0; in_a = '0; in_b = '0; issue_en = 1'b0;
        drive(1'b0, 7'h00, 32'h0, 32'h0, 1'b0, 1'b1);
        drive(1'b0, 7'h00, 32'h0, 32'h0, 1'b0, 1'b1);

        // Single ADD on an idle queue.
        drive(1'b1, 7'h03, 32'd5, 32'd7, 1'b1, 1'b0);
        idle(4, 1'b1);

        // Fill while stalled (fifth offer must be refused), then drain.
        for (int i = 0; i < 5; i++)
            drive(1'b1, 7'(i % 4), 32'(100 + i), 32'(200 + i), 1'b0, 1'b0);
        idle(7, 1'b1);

        // Illegal opcode is consumed but not stored.
        drive(1'b1, 7'h05, 32'h1234, 32'h5678, 1'b0, 1'b0);
        idle(2, 1'b0);
        drive(1'b1, 7'h7F, 32'h1, 32'h2, 1'b1, 1'b0);
        idle(2, 1'b1);

        // Reset with count=3 and one op in flight.
        for (int i = 0; i < 4; i++)
            drive(1'b1, 7'h01, 32'(i + 1), 32'(i + 9), 1'b0, 1'b0);
        idle(1, 1'b1);
        drive(1'b0, 7'h00, 32'h0, 32'h0, 1'b1, 1'b1);
        idle(4, 1'b1);

        // Stall hold after an XOR issue.
        drive(1'b1, 7'h02, 32'hFFFF0000, 32'h0000FFFF, 1'b0, 1'b0);
        drive(1'b1, 7'h00, 32'hA, 32'hB, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++)
            drive(1'b1, 7'h03, 32'(i), 32'(i), 1'b0, 1'b0);
        idle(6, 1'b1);

        // Randomised streaming: tag wrap, simultaneous enqueue/issue, rare resets.
        for (int i = 0; i < 400; i++) begin
            ropc = 7'($urandom_range(0, 3));
            if ($urandom_range(0, 9) == 0) ropc = 7'($urandom_range(4, 127));
            drive(1'($urandom_range(0, 3) != 0), ropc, $urandom, $urandom,
                  1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 99) == 0));
        end
        idle(10, 1'b1);

        @(negedge clk);
        chk("drain_results", 32'(exp_res.size()), 32'(0));
        chk("drain_queue",   32'(mq.size()),      32'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/alu_issue_queue.md
Name: alu_issue_queue

Overview:
- Operand/opcode buffer that sits directly upstream of the 32-bit ALU.
- Accepts {opcode, A, B} operations from the decode stage over a valid/ready handshake and buffers up to DEPTH entries.
- Issues one entry per cycle onto the ALU's registered A/B/opcode inputs.
- Produces a result-valid strobe and tag aligned with the cycle in which the ALU's registered output O is valid, so downstream logic knows when O and the flags belong to a real operation.

Parameters:
- DEPTH, 4, number of queue entries; power of 2, minimum 2.
- TAG_W, 4, width of the issue sequence tag.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  upstream has an operation.
- in_ready  output  1  queue can accept this cycle.
- in_opcode  input  7  ALU opcode.
- in_a  input  32  operand A.
- in_b  input  32  operand B.
- issue_en  input  1  downstream permits issue this cycle; 0 = stall.
- alu_a  output  32  registered operand A to the ALU.
- alu_b  output  32  registered operand B to the ALU.
- alu_opcode  output  7  registered opcode to the ALU.
- alu_issue  output  1  alu_* hold a newly issued operation this cycle.
- res_valid  output  1  ALU output O reflects an issued operation this cycle.
- res_tag  output  TAG_W  tag of the operation whose result is valid.
- res_opcode  output  7  opcode of that operation.
- count  output  $clog2(DEPTH)+1  entries currently stored.
- illegal_op  output  1  one-cycle pulse: an offered opcode was rejected.

Behaviour:
- **Reset.** On rst=1 at a clock edge, all of the following become 0: pointers, count, alu_a, alu_b, alu_opcode, alu_issue, res_valid, res_tag, res_opcode, illegal_op, and the internal tag counter.
  - in_ready is 0 while rst=1.
  - Reset mid-operation discards all queued and in-flight entries; no res_valid for them.
- **Legal opcodes.** 0x00 OR, 0x01 AND, 0x02 XOR, 0x03 ADD.
- **Accept.** A handshake occurs when in_valid && in_ready at a rising edge.
  - Legal opcode: the entry is written at the tail and the tail pointer increments modulo DEPTH.
  - Illegal opcode (>0x03): the entry is consumed (not stored) and illegal_op=1 for the next cycle only.
- **in_ready** = !rst && (count < DEPTH), combinational from registered count. When full, no enqueue occurs even if a dequeue happens in the same cycle; there is no full-bypass.
- **Issue.** At an edge with count > 0 && issue_en:
  - The head entry loads into alu_a, alu_b, alu_opcode.
  - alu_issue <= 1, the head pointer increments modulo DEPTH, and the tag counter increments.
  - Otherwise alu_issue <= 0 and alu_a, alu_b, alu_opcode hold their values; they never change without an issue.
- **No empty bypass.** An entry enqueued at edge t is issued at edge t+1 at the earliest.
- **Result alignment.** The ALU registers O one edge after alu_issue. Therefore:
  - res_valid <= alu_issue.
  - res_tag and res_opcode take the tag and opcode captured with that issue (a one-stage delay pipe).
  - Total latency from accept to res_valid: 3 edges minimum.
- **Tag.** The first issue after reset carries tag 0. The tag wraps from 2^TAG_W-1 to 0.
- **count.** Increments on a legal enqueue alone, decrements on an issue alone, and is unchanged when both occur in the same cycle.
  - Simultaneous enqueue and issue is allowed whenever count is between 1 and DEPTH-1.
- **Stall.** issue_en=0 freezes the head; enqueue continues until full.
- **Wrap-around.** Head and tail each use $clog2(DEPTH) bits; full/empty are determined from count only.

Decomposition:
- Package alu_pkg:
  - DATA_W=32, OPC_W=7.
  - Opcode constants OP_OR=7'h00, OP_AND=7'h01, OP_XOR=7'h02, OP_ADD=7'h03.
  - Function is_legal_op(opc).
  - Shared with the ALU and decode stage.
- One sub-module, sync_fifo (parameter WIDTH, DEPTH; storage, pointers, count), instantiated with WIDTH=71.
- The issue registers, tag counter and result-alignment pipe live in alu_issue_queue.

Test Plan:
- Single op on an idle queue: accept {ADD, A=5, B=7} at edge 0 -> alu_issue=1 after edge 1 with alu_a=5, alu_b=7, alu_opcode=0x03; res_valid=1, res_tag=0, res_opcode=0x03 after edge 2; ALU O=12 in that cycle.
- Fill with issue_en=0: offer 5 legal ops -> in_ready=0 after the 4th accept, count=4, no alu_issue. Raise issue_en -> 4 back-to-back issues in FIFO order, tags 0..3, count 4->0, in_ready=1 after the first issue.
- Illegal opcode: offer opcode 0x05 -> accepted (in_valid && in_ready), illegal_op=1 for exactly one cycle, count unchanged, no issue.
- Simultaneous enqueue and issue at count=2 -> count stays 2. Run 20 ops streaming -> tags wrap 15->0 and every res_tag matches issue order.
- Reset mid-stream: count=3 with one op in flight (alu_issue=1), assert rst for one edge -> next cycle count=0, res_valid=0, alu_*=0, in_ready=0 while rst=1 and 1 after rst drops; no stale result appears.
- Stall hold: issue {XOR, 0xFFFF0000, 0x0000FFFF}, then issue_en=0 for 5 cycles with entries queued -> alu_a, alu_b, alu_opcode stay constant and alu_issue=0 for those 5 cycles.
